fir_serial_filter: RTL and testbench

Time-multiplexed FIR filter that sits directly downstream of the prescaler clock-enable generator in the line-filtering chain. Each single-cycle sample strobe from that generator captures one input sample into a circular delay line. The block then runs one multiply-accumulate per clock over all taps and presents a scaled, registered result with a one-cycle valid pulse. Coefficients are loaded at run time through a simple write port.

---
 rtl/fir_serial_filter_if.sv | 31 +++
 rtl/fir_serial_filter.sv | 122 ++++++++++++
 tb/tb_fir_serial_filter.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/fir_serial_filter_if.sv
// fir_serial_filter_if: sample, coefficient-write and result bundle
// master drives the inputs, slave is the filter.
interface fir_serial_filter_if #(
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int AW     = 4
);
  logic                     i_cen;
  logic signed [DATA_W-1:0] i_data;
  logic                     i_coef_we;
  logic [AW-1:0]            i_coef_addr;
  logic signed [COEF_W-1:0] i_coef_data;
  logic                     i_clr_overrun;
  logic signed [DATA_W-1:0] o_data;
  logic                     o_valid;
  logic                     o_busy;
  logic                     o_overrun;
  logic                     o_coef_err;

  modport master (
    output i_cen, i_data, i_coef_we, i_coef_addr,
    output i_coef_data, i_clr_overrun,
    input  o_data, o_valid, o_busy, o_overrun, o_coef_err
  );

  modport slave (
    input  i_cen, i_data, i_coef_we, i_coef_addr,
    input  i_coef_data, i_clr_overrun,
    output o_data, o_valid, o_busy, o_overrun, o_coef_err
  );
endinterface

// File: rtl/fir_serial_filter.sv
// fir_serial_filter: time-multiplexed FIR, one MAC per clock per tap.
// Optional FIR_SATURATION_EN clamps the output instead of wrapping.
module fir_serial_filter #(
  parameter int TAPS      = 16,
  parameter int DATA_W    = 16,
  parameter int COEF_W    = 16,
  parameter int OUT_SHIFT = 15
) (
  input logic               clk,
  input logic               rst,
  fir_serial_filter_if.slave bus
);
  localparam int AW    = $clog2(TAPS);
  localparam int PW    = DATA_W + COEF_W;
  localparam int ACC_W = PW + AW;

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    OUT
  } state_t;

  state_t state_q, state_d;

  logic signed [DATA_W-1:0] x_mem [TAPS];
  logic signed [COEF_W-1:0] h_mem [TAPS];
  logic [AW-1:0]            wptr_q;
  logic [AW-1:0]            k_q;
  logic [AW-1:0]            rd_idx;
  logic signed [ACC_W-1:0]  acc_q;
  logic signed [PW-1:0]     prod;
  logic signed [DATA_W-1:0] fmt;
  logic                     busy;

  assign busy       = (state_q != IDLE);
  assign bus.o_busy = busy;
  assign rd_idx     = wptr_q - k_q;
  assign prod       = PW'(x_mem[rd_idx]) * PW'(h_mem[k_q]);

`ifdef FIR_SATURATION_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX =
    $signed({{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}});
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    $signed({{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}});

  logic signed [ACC_W-1:0] shifted;
  assign shifted = acc_q >>> OUT_SHIFT;

  // clamp the scaled accumulator into the output range
  always_comb begin
    fmt = shifted[DATA_W-1:0];
    if (shifted > SAT_MAX)
      fmt = {1'b0, {(DATA_W-1){1'b1}}};
    else if (shifted < SAT_MIN)
      fmt = {1'b1, {(DATA_W-1){1'b0}}};
  end
`else
  assign fmt = DATA_W'(acc_q >>> OUT_SHIFT);
`endif

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // next-state: MAC runs exactly TAPS cycles
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (bus.i_cen) state_d = MAC;
      MAC:  if (k_q == AW'(TAPS - 1)) state_d = OUT;
      OUT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // datapath, coefficient port and status flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < TAPS; i++) begin
        x_mem[i] <= '0;
        h_mem[i] <= '0;
      end
      wptr_q         <= '0;
      k_q            <= '0;
      acc_q          <= '0;
      bus.o_data     <= '0;
      bus.o_valid    <= 1'b0;
      bus.o_overrun  <= 1'b0;
      bus.o_coef_err <= 1'b0;
    end else begin
      bus.o_valid    <= 1'b0;
      bus.o_coef_err <= 1'b0;
      if (bus.i_coef_we) begin
        if (busy) bus.o_coef_err <= 1'b1;
        else      h_mem[bus.i_coef_addr] <= bus.i_coef_data;
      end
      if (bus.i_cen && busy)    bus.o_overrun <= 1'b1;
      else if (bus.i_clr_overrun) bus.o_overrun <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.i_cen) begin
            x_mem[wptr_q] <= bus.i_data;
            acc_q         <= '0;
            k_q           <= '0;
          end
        end
        MAC: begin
          acc_q <= acc_q + ACC_W'(prod);
          k_q   <= k_q + 1'b1;
        end
        OUT: begin
          bus.o_data  <= fmt;
          bus.o_valid <= 1'b1;
          wptr_q      <= wptr_q + 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_fir_serial_filter.sv
// tb_fir_serial_filter: directed vectors for fir_serial_filter
// Expected values are hand-derived from h[], x[] and the >>>15 scaling.
module tb_fir_serial_filter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   got, lat, cnt;

  always #5 clk = ~clk;

  fir_serial_filter_if #(.DATA_W(16), .COEF_W(16), .AW(4)) bus ();

  fir_serial_filter #(
    .TAPS(16), .DATA_W(16), .COEF_W(16), .OUT_SHIFT(15)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.i_cen = 1'b0;
    bus.i_coef_we = 1'b0;
    bus.i_clr_overrun = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic coef_wr(input int a, input int v);
    bus.i_coef_we   = 1'b1;
    bus.i_coef_addr = 4'(a);
    bus.i_coef_data = 16'(v);
    tick();
    bus.i_coef_we = 1'b0;
  endtask

  task automatic strobe(input int x);
    bus.i_cen  = 1'b1;
    bus.i_data = 16'(x);
    tick();
    bus.i_cen = 1'b0;
  endtask

  task automatic run_sample(input int x, output int d, output int l);
    int held;
    strobe(x);
    l = 0;
    while (l < 40 && !bus.o_valid) begin
      tick();
      l++;
    end
    if (!bus.o_valid) l = -1;
    d = int'($signed(bus.o_data));
    held = d;
    tick();
    check("valid_one_cycle", int'(bus.o_valid), 0);
    check("data_hold", int'($signed(bus.o_data)), held);
    tick();
  endtask

  initial begin
    bus.i_cen = 1'b0;
    bus.i_data = '0;
    bus.i_coef_we = 1'b0;
    bus.i_coef_addr = '0;
    bus.i_coef_data = '0;
    bus.i_clr_overrun = 1'b0;

    do_reset();
    check("rst_data", int'(bus.o_data), 0);
    check("rst_valid", int'(bus.o_valid), 0);
    check("rst_busy", int'(bus.o_busy), 0);
    check("rst_overrun", int'(bus.o_overrun), 0);
    check("rst_coef_err", int'(bus.o_coef_err), 0);

    // impulse response and latency
    for (int k = 0; k < 16; k++) coef_wr(k, 1024 * (k + 1));
    for (int n = 0; n < 16; n++) begin
      run_sample((n == 0) ? 1000 : 0, got, lat);
      check($sformatf("imp_lat%0d", n), lat, 17);
      check($sformatf("imp_out%0d", n), got,
            (1000 * 1024 * (n + 1)) >>> 15);
    end

    // DC gain
    do_reset();
    for (int k = 0; k < 16; k++) coef_wr(k, 2048);
    for (int n = 0; n < 16; n++) begin
      run_sample(1000, got, lat);
      check($sformatf("dc_out%0d", n), got,
            (1000 * 2048 * (n + 1)) >>> 15);
    end
    run_sample(1000, got, lat);
    check("dc_steady", got, 1000);

    // overrun
    do_reset();
    for (int k = 0; k < 16; k++) coef_wr(k, 1024 * (k + 1));
    strobe(1000);
    check("busy_mac", int'(bus.o_busy), 1);
    check("ovr_before", int'(bus.o_overrun), 0);
    repeat (3) tick();
    strobe(2000);
    check("ovr_set", int'(bus.o_overrun), 1);
    cnt = 0;
    got = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (bus.o_valid) begin
        cnt++;
        got = int'($signed(bus.o_data));
      end
    end
    check("ovr_pulses", cnt, 1);
    check("ovr_out", got, 31);
    run_sample(0, got, lat);
    check("ovr_dline", got, 62);
    check("ovr_sticky", int'(bus.o_overrun), 1);
    bus.i_clr_overrun = 1'b1;
    tick();
    bus.i_clr_overrun = 1'b0;
    check("ovr_clr", int'(bus.o_overrun), 0);
    strobe(0);
    bus.i_cen = 1'b1;
    bus.i_clr_overrun = 1'b1;
    tick();
    bus.i_cen = 1'b0;
    bus.i_clr_overrun = 1'b0;
    check("ovr_set_wins", int'(bus.o_overrun), 1);
    repeat (20) tick();

    // saturation / wrap
    do_reset();
    for (int k = 0; k < 16; k++) coef_wr(k, 32767);
    run_sample(32767, got, lat);
    check("sat_first", got, 32766);
    for (int n = 1; n < 16; n++) run_sample(32767, got, lat);
`ifdef FIR_SATURATION_EN
    check("sat_16th", got, 32767);
`else
    check("wrap_16th", got, -32);
`endif

    // reset mid-MAC
    do_reset();
    coef_wr(0, 16384);
    strobe(1234);
    repeat (4) tick();
    rst = 1'b1;
    #1;
    check("mrst_busy", int'(bus.o_busy), 0);
    check("mrst_valid", int'(bus.o_valid), 0);
    repeat (2) tick();
    rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (bus.o_valid) cnt++;
    end
    check("mrst_no_valid", cnt, 0);
    check("mrst_data", int'(bus.o_data), 0);
    coef_wr(0, 16384);
    run_sample(1000, got, lat);
    check("mrst_after", got, 500);
    check("mrst_lat", lat, 17);

    // coefficient write while busy
    do_reset();
    coef_wr(0, 16384);
    strobe(0);
    bus.i_coef_we   = 1'b1;
    bus.i_coef_addr = 4'd0;
    bus.i_coef_data = 16'sd8192;
    tick();
    bus.i_coef_we = 1'b0;
    check("cerr_pulse", int'(bus.o_coef_err), 1);
    tick();
    check("cerr_clear", int'(bus.o_coef_err), 0);
    repeat (20) tick();
    run_sample(1000, got, lat);
    check("cerr_old_coef", got, 500);
    check("cerr_idle_err", int'(bus.o_coef_err), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
